// File: rtl/rc_pkg.sv
// Shared types and constants for the raster-core front end.
package rc_pkg;

    localparam int RC_WORDS_PER_TRI = 10;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        ARB   = 2'd2,
        SEND  = 2'd3
    } rc_disp_state_t;

    // Index into the triangle buffer (0..9 with the default packet length).
    typedef logic [3:0] rc_word_idx_t;

endpackage

// File: rtl/rc_rr_arbiter.sv
// Round-robin selector: picks the first requesting core after last_grant,
// wrapping modulo NUM_CORES. Purely combinational; the caller registers it.
module rc_rr_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [IDX_W-1:0]     grant,
    output logic                 grant_valid
);

    int cand;

    // Walk offsets 1..NUM_CORES from last_grant; the first set request wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = (int'(last_grant) + i) % NUM_CORES;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/rc_tri_dispatch.sv
// Triangle dispatcher: buffers one complete triangle packet from the host
// stream, then forwards it to one idle raster core chosen round-robin.
// Packets whose tlast does not land on the final word are dropped.
//
// Handshake semantics (both ports): a beat transfers on a rising edge where
// tvalid and tready are both high. tvalid never depends combinationally on
// tready; once raised, tvalid and tdata/tlast hold until that transfer.
module rc_tri_dispatch
    import rc_pkg::*;
#(
    parameter int NUM_CORES     = 2,
    parameter int WORDS_PER_TRI = RC_WORDS_PER_TRI,
    parameter int DATA_W        = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [DATA_W-1:0]    s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic [NUM_CORES-1:0] m_axis_tvalid,
    input  logic [NUM_CORES-1:0] m_axis_tready,
    output logic                 m_axis_tlast,
    input  logic [NUM_CORES-1:0] core_idle,
    output logic [15:0]          tri_count,
    output logic                 drop_pulse,
    output rc_disp_state_t       dbg_state
);

    localparam int           IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam rc_word_idx_t LAST_IDX = rc_word_idx_t'(WORDS_PER_TRI - 1);

    rc_disp_state_t    state, state_next;
    rc_word_idx_t      wr_idx, wr_idx_next;
    rc_word_idx_t      rd_idx, rd_idx_next;
    logic [IDX_W-1:0]  grant, grant_next;
    logic [IDX_W-1:0]  last_grant, last_grant_next;
    logic [15:0]       tri_count_next;
    logic              drop_next;
    logic              buf_we;
    logic              in_hs;
    logic              out_hs;
    logic [IDX_W-1:0]  arb_grant;
    logic              arb_valid;

    logic [DATA_W-1:0] tri_buf [WORDS_PER_TRI];

    rc_rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req         (core_idle),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // Input side is open in FILL and DRAIN; held closed while reset is asserted
    // so it only rises in the first cycle after reset releases.
    assign s_axis_tready = !areset && ((state == FILL) || (state == DRAIN));
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign out_hs        = (state == SEND) && m_axis_tready[grant];
    assign dbg_state     = state;

    // State and counter registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= FILL;
            wr_idx     <= '0;
            rd_idx     <= '0;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_CORES - 1);
            tri_count  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            wr_idx     <= wr_idx_next;
            rd_idx     <= rd_idx_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            tri_count  <= tri_count_next;
            drop_pulse <= drop_next;
        end
    end

    // Triangle buffer write port; no reset needed, contents are only read in SEND.
    always_ff @(posedge aclk) begin
        if (buf_we) begin
            tri_buf[wr_idx] <= s_axis_tdata;
        end
    end

    // Next-state logic: fill, drain malformed packets, arbitrate, send.
    always_comb begin
        state_next      = state;
        wr_idx_next     = wr_idx;
        rd_idx_next     = rd_idx;
        grant_next      = grant;
        last_grant_next = last_grant;
        tri_count_next  = tri_count;
        drop_next       = 1'b0;
        buf_we          = 1'b0;
        case (state)
            FILL: begin
                if (in_hs) begin
                    buf_we = 1'b1;
                    if (s_axis_tlast) begin
                        if (wr_idx == LAST_IDX) begin
                            state_next = ARB;
                        end else begin
                            drop_next   = 1'b1;
                            wr_idx_next = '0;
                        end
                    end else if (wr_idx == LAST_IDX) begin
                        state_next = DRAIN;
                    end else begin
                        wr_idx_next = wr_idx + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (in_hs && s_axis_tlast) begin
                    drop_next   = 1'b1;
                    wr_idx_next = '0;
                    state_next  = FILL;
                end
            end
            ARB: begin
                if (arb_valid) begin
                    grant_next = arb_grant;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (rd_idx == LAST_IDX) begin
                        tri_count_next  = tri_count + 16'd1;
                        last_grant_next = grant;
                        rd_idx_next     = '0;
                        wr_idx_next     = '0;
                        state_next      = FILL;
                    end else begin
                        rd_idx_next = rd_idx + 4'd1;
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Output stream: data and valid are functions of registered state only.
    always_comb begin
        m_axis_tvalid = '0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        if (state == SEND) begin
            m_axis_tdata = tri_buf[rd_idx];
            m_axis_tlast = (rd_idx == LAST_IDX);
            for (int i = 0; i < NUM_CORES; i++) begin
                m_axis_tvalid[i] = (grant == IDX_W'(i));
            end
        end
    end

endmodule

// File: tb/tb_rc_tri_dispatch.sv
// Directed bench for rc_tri_dispatch with two cores.
module tb_rc_tri_dispatch;
    import rc_pkg::*;

    logic        aclk;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [1:0]  m_axis_tvalid;
    logic [1:0]  m_axis_tready;
    logic        m_axis_tlast;
    logic [1:0]  core_idle;
    logic [15:0] tri_count;
    logic        drop_pulse;
    rc_disp_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_tri = 0;
    int t0;
    logic [31:0] exp_q[$];

    rc_tri_dispatch #(
        .NUM_CORES     (2),
        .WORDS_PER_TRI (10),
        .DATA_W        (32)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .core_idle     (core_idle),
        .tri_count     (tri_count),
        .drop_pulse    (drop_pulse),
        .dbg_state     (dbg_state)
    );

    // Clock and cycle counter.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int c);
        logic [1:0] one;
        one = 2'b01;
        return one << c;
    endfunction

    task automatic do_reset();
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        @(negedge aclk);
        @(negedge aclk);
        check("rst_s_ready", s_axis_tready, 0);
        check("rst_m_valid", m_axis_tvalid, 0);
        check("rst_m_data", m_axis_tdata, 0);
        check("rst_m_last", m_axis_tlast, 0);
        check("rst_tri_count", tri_count, 0);
        check("rst_drop", drop_pulse, 0);
        check("rst_state", dbg_state, FILL);
        areset = 1'b0;
        @(negedge aclk);
        check("rst_ready_rise", s_axis_tready, 1);
        exp_tri = 0;
    endtask

    // Drive n beats (tlast on the final one) at full rate. Good 10-beat
    // packets are queued on the scoreboard. Returns at the cycle after the
    // final beat was accepted.
    task automatic send_packet(input int n, input logic [31:0] base, input bit rnd);
        logic [31:0] w;
        for (int b = 0; b < n; b++) begin
            w = rnd ? $urandom : base + 32'(b);
            check("in_ready", s_axis_tready, 1);
            check("in_state", dbg_state, (b < 10) ? FILL : DRAIN);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = w;
            s_axis_tlast  = (b == n - 1);
            if (n == 10) exp_q.push_back(w);
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (n == 10) begin
            check("arb_state", dbg_state, ARB);
            check("arb_ready_low", s_axis_tready, 0);
            check("arb_no_valid", m_axis_tvalid, 0);
            check("arb_no_drop", drop_pulse, 0);
        end else begin
            check("drop_pulse_hi", drop_pulse, 1);
            check("drop_state", dbg_state, FILL);
            check("drop_no_valid", m_axis_tvalid, 0);
            @(negedge aclk);
            check("drop_pulse_lo", drop_pulse, 0);
            check("drop_no_valid2", m_axis_tvalid, 0);
        end
    endtask

    // Consume the queued triangle on the given core. With rnd set, that core's
    // ready toggles randomly while the other core's ready stays high.
    task automatic receive(input int core, input bit rnd);
        int   guard = 0;
        bit   stalled = 0;
        logic rdy;
        logic [31:0] held;
        while (exp_q.size() > 0 && guard < 400) begin
            check("out_valid", m_axis_tvalid, oh(core));
            if (stalled) check("stall_data", m_axis_tdata, held);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axis_tready       = 2'b11;
            m_axis_tready[core] = rdy;
            if (rdy) begin
                check("out_data", m_axis_tdata, exp_q[0]);
                check("out_last", m_axis_tlast, (exp_q.size() == 1) ? 1 : 0);
                void'(exp_q.pop_front());
                stalled = 0;
            end else begin
                held    = m_axis_tdata;
                stalled = 1;
            end
            @(negedge aclk);
            guard++;
        end
        check("recv_timeout", exp_q.size(), 0);
        m_axis_tready = 2'b11;
        exp_tri++;
        check("tri_count", tri_count, exp_tri);
        check("post_send_state", dbg_state, FILL);
        check("post_send_valid", m_axis_tvalid, 0);
        check("post_send_ready", s_axis_tready, 1);
    endtask

    initial begin
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 2'b11;
        core_idle     = 2'b11;
        @(negedge aclk);

        // Basic triangle 0..9 to core 0, valid two cycles after last beat.
        do_reset();
        send_packet(10, 32'h0, 0);
        @(negedge aclk);
        receive(0, 0);

        // Three back-to-back triangles: cores 0,1,0 at 21 cycles each.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            t0 = cyc;
            send_packet(10, 32'h1000 * (k + 1), 0);
            @(negedge aclk);
            receive(k % 2, 0);
            check("tri_cycles", cyc - t0, 21);
        end

        // No idle core: wait in ARB, then only core 1 idle.
        core_idle = 2'b00;
        send_packet(10, 32'h5000, 0);
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            check("wait_arb_state", dbg_state, ARB);
            check("wait_arb_ready", s_axis_tready, 0);
        end
        core_idle = 2'b10;
        @(negedge aclk);
        receive(1, 0);
        core_idle = 2'b11;

        // Short packet (tlast on beat 4), then a good packet to core 0.
        send_packet(5, 32'h6000, 0);
        check("short_tri_count", tri_count, exp_tri);
        send_packet(10, 32'h7000, 0);
        @(negedge aclk);
        receive(0, 0);

        // Long packet: 13 beats drained, one drop, count unchanged.
        send_packet(13, 32'h8000, 0);
        check("long_tri_count", tri_count, exp_tri);

        // Random data, granted core (1) stalls randomly.
        send_packet(10, 32'h0, 1);
        @(negedge aclk);
        receive(1, 1);

        // tlast on beat 0 is a short packet.
        send_packet(1, 32'h9000, 0);

        // Reset in the middle of SEND aborts the triangle.
        send_packet(10, 32'h100, 0);
        @(negedge aclk);
        check("abort_valid", m_axis_tvalid, oh(0));
        for (int k = 0; k < 3; k++) @(negedge aclk);
        check("abort_data_mid", m_axis_tdata, 32'h103);
        areset = 1'b1;
        @(negedge aclk);
        exp_q.delete();
        check("abort_valid_low", m_axis_tvalid, 0);
        check("abort_data_zero", m_axis_tdata, 0);
        check("abort_last_zero", m_axis_tlast, 0);
        check("abort_tri_count", tri_count, 0);
        check("abort_state", dbg_state, FILL);
        check("abort_s_ready", s_axis_tready, 0);
        areset = 1'b0;
        exp_tri = 0;
        @(negedge aclk);
        check("abort_ready_rise", s_axis_tready, 1);
        send_packet(10, 32'h200, 0);
        @(negedge aclk);
        receive(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
